// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element datapath: Booth multiplier
// state encoding and Booth recoding select values.
package pe_pkg;

  typedef enum logic [1:0] {
    BOOTH_IDLE = 2'b00,
    BOOTH_RUN  = 2'b01,
    BOOTH_FIN  = 2'b10
  } booth_state_t;

  // {Q[0], q_m1} patterns that modify the partial product
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_m1}. Purely combinational.
module booth_step
  import pe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m_reg,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  // recode on the two low multiplier bits, then shift with sign replication
  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      BOOTH_ADD: sum = a + m_reg;
      BOOTH_SUB: sum = a - m_reg;
      default:   sum = a;
    endcase
    a_next    = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_mantissa_mul.sv
// Sequential radix-2 Booth multiplier for the PE signed mantissa operands.
// One iteration per clock; product and a one-cycle done pulse appear
// WIDTH+1 cycles after the accepting edge.
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand skips the
// iterations and completes on the very next edge.
module booth_mantissa_mul
  import pe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  act,
  input  logic [WIDTH-1:0]      multiplicand,
  input  logic [WIDTH-1:0]      multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  booth_state_t     state;
  // A carries one extra bit so A - M cannot overflow for M = -2^(WIDTH-1)
  logic [WIDTH:0]   a, a_nx;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q, q_nx;
  logic             q_m1, q_m1_nx;
  logic [CNT_W-1:0] cnt;
  logic             zero_op;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a),
    .q         (q),
    .q_m1      (q_m1),
    .m_reg     (m_reg),
    .a_next    (a_nx),
    .q_next    (q_nx),
    .q_m1_next (q_m1_nx)
  );

  assign busy = (state != BOOTH_IDLE);

  // control FSM and datapath registers; rst over clr, both abort silently
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst || clr) begin
      state   <= BOOTH_IDLE;
      a       <= '0;
      m_reg   <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        BOOTH_IDLE: begin
          if (act) begin
            if (zero_op) begin
              // zero operand: product is zero, go straight to completion
              a     <= '0;
              m_reg <= '0;
              q     <= '0;
              q_m1  <= 1'b0;
              cnt   <= '0;
              state <= BOOTH_FIN;
            end else begin
              m_reg <= {multiplicand[WIDTH-1], multiplicand};
              a     <= '0;
              q     <= multiplier;
              q_m1  <= 1'b0;
              cnt   <= CNT_W'(WIDTH);
              state <= BOOTH_RUN;
            end
          end
        end
        BOOTH_RUN: begin
          a    <= a_nx;
          q    <= q_nx;
          q_m1 <= q_m1_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= BOOTH_FIN;
        end
        BOOTH_FIN: begin
          product <= {a[WIDTH-1:0], q};
          done    <= 1'b1;
          state   <= BOOTH_IDLE;
        end
        default: state <= BOOTH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mantissa_mul.sv
// Scoreboard bench for booth_mantissa_mul (WIDTH=8). The driver pushes the
// expected product and completion cycle per accepted operation; a monitor
// on the falling edge checks done, product, and busy every cycle.
module tb_booth_mantissa_mul;

  localparam int W   = 8;
  localparam int INF = 32'h7fff_ffff;

  logic             clk = 1'b0;
  logic             rst, clr, act;
  logic [W-1:0]     multiplicand, multiplier;
  logic             busy, done;
  logic [2*W-1:0]   product;

  booth_mantissa_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .act          (act),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] exp;
    int             acc;
    int             fin;
    int             abort;
  } ent_t;

  ent_t           sb[$];
  int             cyc = 0;
  int             vec = 0;
  int             err = 0;
  int             clr_at = INF;
  bit             mon_en = 1'b0;
  logic [2*W-1:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint actv, input longint expv);
    vec++;
    if (actv != expv) begin
      err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, actv, expv);
    end
  endtask

  // reference: plain signed integer multiply truncated to 2W bits
  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    int pm, pq, p;
    pm = $signed(m);
    pq = $signed(q);
    p  = pm * pq;
    return p[2*W-1:0];
  endfunction

  // monitor: scoreboard pop on done, product hold, busy window
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t e;
      bit   exp_busy;
      if (cyc >= clr_at) begin
        last_prod = '0;
        clr_at    = INF;
      end
      while (sb.size() > 0 && sb[0].abort != 0 && cyc >= sb[0].abort)
        void'(sb.pop_front());
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].fin);
      if (done) begin
        if (sb.size() == 0) begin
          vec++;
          err++;
          $display("FAIL unexpected_done @cyc %0d: got done=1 expected done=0", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.fin);
          chk("product", product, e.exp);
          last_prod = e.exp;
        end
      end else begin
        if (sb.size() > 0 && cyc >= sb[0].fin) begin
          vec++;
          err++;
          $display("FAIL missing_done @cyc %0d: got done=0 expected done=1", cyc);
          void'(sb.pop_front());
        end
        chk("product_hold", product, last_prod);
      end
      chk("busy", busy, exp_busy);
    end
  end

  // drive one start; must be called at a falling edge
  task automatic start(input logic [W-1:0] m, input logic [W-1:0] q);
    ent_t e;
    int   lat;
    lat = W + 1;
`ifdef BOOTH_ZERO_SKIP_EN
    if (m == '0 || q == '0) lat = 1;
`endif
    multiplicand = m;
    multiplier   = q;
    act          = 1'b1;
    e.exp   = model(m, q);
    e.acc   = cyc + 1;
    e.fin   = e.acc + lat;
    e.abort = 0;
    sb.push_back(e);
    @(negedge clk);
    act          = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      vec++;
      err++;
      $display("FAIL wait_done_timeout @cyc %0d: got no done expected done", cyc);
    end
  endtask

  // abort whatever is in flight with clr (or rst)
  task automatic abort_op(input bit use_rst);
    ent_t e;
    if (sb.size() > 0) begin
      e = sb[sb.size()-1];
      e.abort = cyc + 1;
      sb[sb.size()-1] = e;
    end
    clr_at = cyc + 1;
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    chk(use_rst ? "rst_product" : "clr_product", product, 0);
    chk(use_rst ? "rst_busy" : "clr_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; act = 1'b0;
    multiplicand = '0; multiplier = '0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;
    repeat (3) @(negedge clk);

    // basic and signed corners
    start(8'd3, 8'd5);              wait_done();
    start(-8'sd7, 8'd6);            wait_done();
    start(8'h80, 8'h80);            wait_done();
    start(8'd127, 8'h80);           wait_done();
    start(8'hFF, 8'hFF);            wait_done();
    // back-to-back: act on the done cycle
    start(8'd9, 8'd11);             wait_done();
    start(8'd2, 8'd2);              wait_done();
    repeat (2) @(negedge clk);

    // act pulses while busy must be ignored
    start(8'd13, 8'hF3);
    @(negedge clk); act = 1'b1; multiplicand = 8'd1; multiplier = 8'd1;
    @(negedge clk); act = 1'b0;
    @(negedge clk); act = 1'b1;
    @(negedge clk); act = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);

    // clr mid-run, rst mid-run, clr+act in idle
    start(8'd21, 8'd33);
    repeat (2) @(negedge clk);
    abort_op(1'b0);
    repeat (12) @(negedge clk);
    start(8'd45, 8'hC1);
    repeat (3) @(negedge clk);
    abort_op(1'b1);
    repeat (12) @(negedge clk);
    act = 1'b1; multiplicand = 8'd4; multiplier = 8'd4;
    abort_op(1'b0);
    act = 1'b0;
    repeat (12) @(negedge clk);

    // zero operand
    start(8'd0, -8'sd5);            wait_done();
    start(8'd77, 8'd0);             wait_done();

    // randomized traffic with gaps of 0..3 idle cycles
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] m, q;
      int gap;
      m = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      q = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      start(m, q);
      wait_done();
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    // drain
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vec++;
      err++;
      $display("FAIL drain @cyc %0d: got %0d pending expected 0", cyc, sb.size());
    end
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
